gpio_in_responder: RTL and testbench



---
 rtl/gpio_in_pkg.sv | 26 ++
 rtl/gpio_in_debounce_bit.sv | 69 ++++++
 rtl/gpio_in_responder.sv | 183 ++++++++++++++++++
 tb/tb_gpio_in_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_pkg.sv
// -----------------------------------------------------------------------------
// gpio_in_pkg
// Shared constants for the GPIO input responder:
//   - word offsets (Address[4:2]) of the register window
//   - width of the DEB_CFG prescaler reload register
//   - helper that sizes the per-bit stability counter from STABLE_SAMPLES
// -----------------------------------------------------------------------------
package gpio_in_pkg;

  localparam int OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_DATA    = 3'd0;  // 0x00 debounced pins
  localparam logic [OFF_W-1:0] OFF_RAW     = 3'd1;  // 0x04 synchronised pins
  localparam logic [OFF_W-1:0] OFF_RISE    = 3'd2;  // 0x08 rising-edge status
  localparam logic [OFF_W-1:0] OFF_FALL    = 3'd3;  // 0x0C falling-edge status
  localparam logic [OFF_W-1:0] OFF_DEBCFG  = 3'd4;  // 0x10 prescaler reload
  localparam logic [OFF_W-1:0] OFF_IRQMASK = 3'd5;  // 0x14 interrupt mask

  localparam int DEB_CFG_W = 16;

  // The counter holds 0..STABLE_SAMPLES-1.
  function automatic int cnt_width(input int stable_samples);
    return (stable_samples <= 2) ? 1 : $clog2(stable_samples);
  endfunction

endpackage

// File: rtl/gpio_in_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_in_debounce_bit
// Debounces one synchronised input bit. On each prescaler tick the raw level
// is compared against the accepted level; a differing level must persist for
// STABLE_SAMPLES consecutive ticks before it is accepted. The first tick after
// reset (primed low) loads the raw level directly without reporting an edge.
//
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-high reset
//   tick       in  sample enable from the prescaler
//   primed     in  high once the first post-reset tick has happened
//   raw        in  synchronised pin level
//   level      out accepted (debounced) level
//   rise_pulse out high in the cycle level is about to change 0->1
//   fall_pulse out high in the cycle level is about to change 1->0
// -----------------------------------------------------------------------------
module gpio_in_debounce_bit #(
  parameter int STABLE_SAMPLES = 3,
  parameter int CNT_W          = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic primed,
  input  logic raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (!primed) begin
        level_d = raw;
        cnt_d   = '0;
      end else if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
        level_d = raw;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pulses are next-state based so the status bits set on the same edge
  // that the accepted level changes. The priming load never reports.
  assign rise_pulse = primed & ~level_q &  level_d;
  assign fall_pulse = primed &  level_q & ~level_d;
  assign level      = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_in_responder.sv
// -----------------------------------------------------------------------------
// gpio_in_responder
// Memory-mapped responder for the GPIO input path. Synchronises and debounces
// the external pins, latches rising/falling edges into write-1-to-clear status
// registers and exposes a 32-byte register window to the core.
//
// Register window (byte offsets from BASE_ADDR):
//   0x00 DATA     RO  debounced pins
//   0x04 RAW      RO  synchronised pins
//   0x08 RISE     W1C rising-edge status
//   0x0C FALL     W1C falling-edge status
//   0x10 DEB_CFG  RW  [15:0] prescaler reload (tick every DEB_CFG+1 cycles)
//   0x14 IRQ_MASK RW  [2*GPIO_WIDTH-1:0] when GPIO_IRQ_EN is defined, else 0
//   0x18/0x1C         read 0
//
// Build option: define GPIO_IRQ_EN to build the interrupt mask and the
// registered irq output; otherwise irq is tied low and no mask flops exist.
//
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   sel          in  chip select, qualifies read and write
//   Address      in  byte address
//   WriteData    in  write data
//   MemWrite     in  write strobe
//   ReadData     out combinational read data (0 when not selected)
//   gpio_port_in in  asynchronous external pins
//   irq          out level interrupt
// -----------------------------------------------------------------------------
module gpio_in_responder
  import gpio_in_pkg::*;
#(
  parameter int          GPIO_WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h1001_0020,
  parameter int          STABLE_SAMPLES = 3,
  parameter logic [15:0] DEB_RESET      = 16'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic [31:0]           Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemWrite,
  output logic [31:0]           ReadData,
  input  logic [GPIO_WIDTH-1:0] gpio_port_in,
  output logic                  irq
);

  localparam int CNT_W = cnt_width(STABLE_SAMPLES);

  // Address decode
  logic             addr_hit;
  logic             acc;
  logic             wr;
  logic [OFF_W-1:0] off;

  assign addr_hit = (Address[31:5] == BASE_ADDR[31:5]);
  assign acc      = sel & addr_hit;
  assign wr       = acc & MemWrite;
  assign off      = Address[4:2];

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], WriteData};

  // Synchroniser and register state
  logic [GPIO_WIDTH-1:0] sync1_q, raw_q;
  logic                  fill_q, sync_full_q;
  logic [DEB_CFG_W-1:0]  presc_q, presc_d;
  logic [DEB_CFG_W-1:0]  debcfg_q, debcfg_d;
  logic                  primed_q;
  logic [GPIO_WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [GPIO_WIDTH-1:0] data_lvl, rise_p, fall_p;
  logic                  presc_tick, tick;

  assign presc_tick = (presc_q == debcfg_q);
  // Ticks are held off until both synchroniser stages hold real pin samples,
  // so the priming load captures the pins rather than the reset zeros.
  assign tick       = presc_tick & sync_full_q;

  always_comb begin
    presc_d  = presc_q;
    debcfg_d = debcfg_q;
    if (wr && off == OFF_DEBCFG) begin
      debcfg_d = WriteData[DEB_CFG_W-1:0];
      presc_d  = '0;
    end else if (presc_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + DEB_CFG_W'(1);
    end
  end

  // W1C with set priority: the new pulse is OR-ed after the clear mask.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (wr && off == OFF_RISE) rise_d = rise_q & ~WriteData[GPIO_WIDTH-1:0];
    if (wr && off == OFF_FALL) fall_d = fall_q & ~WriteData[GPIO_WIDTH-1:0];
    rise_d = rise_d | rise_p;
    fall_d = fall_d | fall_p;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      raw_q       <= '0;
      fill_q      <= 1'b0;
      sync_full_q <= 1'b0;
      presc_q     <= '0;
      debcfg_q    <= DEB_RESET;
      primed_q    <= 1'b0;
      rise_q      <= '0;
      fall_q      <= '0;
    end else begin
      sync1_q     <= gpio_port_in;
      raw_q       <= sync1_q;
      fill_q      <= 1'b1;
      sync_full_q <= fill_q;
      presc_q     <= presc_d;
      debcfg_q    <= debcfg_d;
      if (tick) primed_q <= 1'b1;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
    end
  end

  // Per-bit debounce
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_in_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .primed    (primed_q),
      .raw       (raw_q[i]),
      .level     (data_lvl[i]),
      .rise_pulse(rise_p[i]),
      .fall_pulse(fall_p[i])
    );
  end

`ifdef GPIO_IRQ_EN
  logic [2*GPIO_WIDTH-1:0] mask_q;
  logic                    irq_q;

  // irq is computed from the registered status, so it lags status by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && off == OFF_IRQMASK) mask_q <= WriteData[2*GPIO_WIDTH-1:0];
      irq_q <= (|(rise_q & mask_q[GPIO_WIDTH-1:0])) |
               (|(fall_q & mask_q[2*GPIO_WIDTH-1:GPIO_WIDTH]));
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux
  always_comb begin
    ReadData = '0;
    if (acc) begin
      case (off)
        OFF_DATA:    ReadData[GPIO_WIDTH-1:0] = data_lvl;
        OFF_RAW:     ReadData[GPIO_WIDTH-1:0] = raw_q;
        OFF_RISE:    ReadData[GPIO_WIDTH-1:0] = rise_q;
        OFF_FALL:    ReadData[GPIO_WIDTH-1:0] = fall_q;
        OFF_DEBCFG:  ReadData[DEB_CFG_W-1:0]  = debcfg_q;
`ifdef GPIO_IRQ_EN
        OFF_IRQMASK: ReadData[2*GPIO_WIDTH-1:0] = mask_q;
`endif
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_in_responder.sv
module tb_gpio_in_responder;

  localparam logic [31:0] A_DATA = 32'h1001_0020;
  localparam logic [31:0] A_RAW  = 32'h1001_0024;
  localparam logic [31:0] A_RISE = 32'h1001_0028;
  localparam logic [31:0] A_FALL = 32'h1001_002C;
  localparam logic [31:0] A_DEB  = 32'h1001_0030;
  localparam logic [31:0] A_MASK = 32'h1001_0034;
  localparam logic [31:0] A_UNM  = 32'h1001_0038;
  localparam logic [31:0] A_OUT  = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [7:0]  gpio_port_in;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  gpio_in_responder dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .ReadData    (ReadData),
    .gpio_port_in(gpio_port_in),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational read between clock edges; no edge is consumed.
  task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    sel      = 1'b1;
    MemWrite = 1'b0;
    Address  = addr;
    #1;
    d        = ReadData;
    sel      = 1'b0;
    Address  = '0;
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    sel       = 1'b1;
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = data;
    @(posedge clk);
    #1;
    sel       = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    sel          = 1'b0;
    Address      = '0;
    WriteData    = '0;
    MemWrite     = 1'b0;
    gpio_port_in = 8'hA5;

    // Reset state
    step(3);
    check("rd_unselected", ReadData, 32'h0);
    check("irq_reset", {31'b0, irq}, 32'h0);
    chk_reg("data_in_reset", A_DATA, 32'h0);
    chk_reg("debcfg_reset", A_DEB, 32'h0);

    // Priming: DATA follows the pins from the 3rd cycle, no edges
    reset = 1'b0;
    step(2);
    chk_reg("data_cycle2", A_DATA, 32'h0);
    step(1);
    chk_reg("data_cycle3", A_DATA, 32'hA5);
    chk_reg("raw_cycle3", A_RAW, 32'hA5);
    chk_reg("rise_after_prime", A_RISE, 32'h0);
    chk_reg("fall_after_prime", A_FALL, 32'h0);

    // All pins low: falling edges on A5, then clear them
    gpio_port_in = 8'h00;
    step(8);
    chk_reg("data_low", A_DATA, 32'h0);
    chk_reg("fall_a5", A_FALL, 32'hA5);
    wr(A_FALL, 32'hFFFF_FFA5);
    chk_reg("fall_cleared", A_FALL, 32'h0);

    // bit0 rises: accepted on the 5th edge counting the sampling edge
    gpio_port_in = 8'h01;
    step(4);
    chk_reg("bit0_edge4", A_DATA, 32'h0);
    step(1);
    chk_reg("bit0_edge5", A_DATA, 32'h01);
    chk_reg("rise_bit0", A_RISE, 32'h01);
    chk_reg("fall_none", A_FALL, 32'h0);

    // bit3 glitch of 2 cycles is rejected
    gpio_port_in = 8'h09;
    step(2);
    gpio_port_in = 8'h01;
    step(6);
    chk_reg("glitch_data", A_DATA, 32'h01);
    chk_reg("glitch_rise", A_RISE, 32'h01);

    // bit0 falls, then rises again with a W1C on the same edge: set wins
    gpio_port_in = 8'h00;
    step(6);
    chk_reg("bit0_low", A_DATA, 32'h0);
    chk_reg("fall_bit0", A_FALL, 32'h01);
    gpio_port_in = 8'h01;
    step(4);
    wr(A_RISE, 32'h1);
    chk_reg("set_wins_data", A_DATA, 32'h01);
    chk_reg("set_wins_rise", A_RISE, 32'h01);
    wr(A_RISE, 32'h1);
    chk_reg("w1c_rise", A_RISE, 32'h0);
    wr(A_FALL, 32'h1);
    chk_reg("w1c_fall", A_FALL, 32'h0);

    // DEB_CFG=4: ticks 5, 10, 15 edges after the write; bit1 accepted at 15
    wr(A_DEB, 32'hFFFF_0004);
    gpio_port_in = 8'h03;
    chk_reg("debcfg_rd", A_DEB, 32'h4);
    step(14);
    chk_reg("deb4_edge14", A_DATA, 32'h01);
    chk_reg("deb4_raw", A_RAW, 32'h03);
    step(1);
    chk_reg("deb4_edge15", A_DATA, 32'h03);
    chk_reg("deb4_rise", A_RISE, 32'h02);
    wr(A_DATA, 32'hFFFF_FFFF);
    chk_reg("ro_data_write", A_DATA, 32'h03);

    // Unmapped, out-of-window and unselected reads
    wr(A_UNM, 32'hFFFF_FFFF);
    chk_reg("unmapped_rd", A_UNM, 32'h0);
    chk_reg("out_of_window", A_OUT, 32'h0);
    Address = A_DEB;
    #1;
    check("sel_low_hit", ReadData, 32'h0);
    Address = '0;

    // Mask and interrupt
    wr(A_DEB, 32'h0);
    wr(A_MASK, 32'h0000_0100);
    gpio_port_in = 8'h02;
    step(4);
    chk_reg("irq_fall_pre", A_FALL, 32'h0);
    step(1);
    chk_reg("irq_fall_set", A_FALL, 32'h01);
    check("irq_same_cycle", {31'b0, irq}, 32'h0);
`ifdef GPIO_IRQ_EN
    chk_reg("mask_rd", A_MASK, 32'h0000_0100);
    step(1);
    check("irq_asserted", {31'b0, irq}, 32'h1);
    wr(A_FALL, 32'h1);
    chk_reg("irq_fall_clr", A_FALL, 32'h0);
    check("irq_lags_clear", {31'b0, irq}, 32'h1);
    step(1);
    check("irq_deasserted", {31'b0, irq}, 32'h0);
`else
    chk_reg("mask_rd_zero", A_MASK, 32'h0);
    step(1);
    check("irq_tied_low", {31'b0, irq}, 32'h0);
    wr(A_FALL, 32'h1);
    chk_reg("irq_fall_clr", A_FALL, 32'h0);
`endif

    // Reset mid-operation clears sticky status and restarts priming
    chk_reg("rise_before_reset", A_RISE, 32'h02);
    gpio_port_in = 8'h5A;
    wr(A_DEB, 32'h7);
    reset = 1'b1;
    step(1);
    chk_reg("mid_rst_rise", A_RISE, 32'h0);
    chk_reg("mid_rst_data", A_DATA, 32'h0);
    chk_reg("mid_rst_raw", A_RAW, 32'h0);
    chk_reg("mid_rst_debcfg", A_DEB, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    step(2);
    chk_reg("reprime_cycle2", A_DATA, 32'h0);
    step(1);
    chk_reg("reprime_cycle3", A_DATA, 32'h5A);
    chk_reg("reprime_rise", A_RISE, 32'h0);
    chk_reg("reprime_fall", A_FALL, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
